// File: rtl/logic_gate_unit.sv
// Pipelined bitwise logic unit: eight two-operand functions over WIDTH-bit vectors,
// STAGES-deep valid/ready pipeline with reduction flags and an accepted-beat counter.
module logic_gate_unit #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             C_and,
  output logic             C_or,
  output logic             C_par,
  input  logic             cnt_clr,
  output logic [15:0]      op_count,
  output logic             busy
);

  // A beat is {parity, or-reduce, and-reduce, result} so flags always match C.
  localparam int BEAT_W = WIDTH + 3;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (sel)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return ~(a & b);
      3'b100:  return ~(a | b);
      3'b101:  return ~(a ^ b);
      3'b110:  return ~a;
      default: return b;
    endcase
  endfunction

  function automatic logic [BEAT_W-1:0] pack_beat(input logic [WIDTH-1:0] r);
    return {^r, |r, &r, r};
  endfunction

  logic              vld_p0;
  logic [BEAT_W-1:0] beat_p0;
  logic [STAGES-1:0] vld_p;
  logic [BEAT_W-1:0] beat_p [STAGES];
  logic [STAGES-1:0] load_p;
  logic [STAGES-1:0] feed_v;
  logic [BEAT_W-1:0] feed_d [STAGES];
  logic              go;

  // ---- stage 0: combinational function and reductions ----
  assign vld_p0  = in_valid && in_ready;
  assign beat_p0 = pack_beat(apply_op(op, A, B));

  // A stage loads when empty or when its contents move on; this ripples
  // from out_ready back to in_ready with no skid storage.
  always_comb begin
    go = out_ready;
    load_p = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load_p[k] = ~vld_p[k] | go;
      go        = load_p[k];
    end
    in_ready = load_p[0];
  end

  always_comb begin
    feed_v[0] = vld_p0;
    feed_d[0] = beat_p0;
    for (int k = 1; k < STAGES; k++) begin
      feed_v[k] = vld_p[k-1];
      feed_d[k] = beat_p[k-1];
    end
  end

  // ---- stages 1..STAGES: registered beats ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int k = 0; k < STAGES; k++) beat_p[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_p[k]) begin
          vld_p[k] <= feed_v[k];
          if (feed_v[k]) beat_p[k] <= feed_d[k];
        end
      end
    end
  end

  // Clear wins over a coincident accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      op_count <= '0;
    else if (cnt_clr) op_count <= '0;
    else if (vld_p0)  op_count <= op_count + 16'd1;
  end

  // ---- output: last stage ----
  assign out_valid = vld_p[STAGES-1];
  assign {C_par, C_or, C_and, C} = beat_p[STAGES-1];
  assign busy = |vld_p;

endmodule
